// File: rtl/pattern_sequencer_pkg.sv
// pattern_seq_pkg: shared types for the song-level pattern sequencer.
// State enum, order-word field layout and slicing helpers.
package pattern_seq_pkg;

  localparam int PAT_ADDR_W = 5;

  localparam int OW_ADDR_LSB = 0;
  localparam int OW_ADDR_W   = 5;
  localparam int OW_LEN_LSB  = 5;
  localparam int OW_LEN_W    = 5;
  localparam int OW_REP_LSB  = 10;
  localparam int OW_REP_W    = 4;
  localparam int OW_END_BIT  = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ARM,
    S_PLAY
  } state_t;

  function automatic logic [OW_ADDR_W-1:0] ow_addr(
    input logic [15:0] w
  );
    return w[OW_ADDR_LSB +: OW_ADDR_W];
  endfunction

  function automatic logic [OW_LEN_W-1:0] ow_len(
    input logic [15:0] w
  );
    return w[OW_LEN_LSB +: OW_LEN_W];
  endfunction

  function automatic logic [OW_REP_W-1:0] ow_rep(
    input logic [15:0] w
  );
    return w[OW_REP_LSB +: OW_REP_W];
  endfunction

  function automatic logic ow_end(
    input logic [15:0] w
  );
    return w[OW_END_BIT];
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Link between pattern sequencer (master) and note sequencer (slave).
// Ports: i_note_stb, i_note_done in; o_new_addr/len/valid out.
interface pattern_sequencer_if;
  import pattern_seq_pkg::*;

  logic                  i_note_stb;
  logic                  i_note_done;
  logic [PAT_ADDR_W-1:0] o_new_addr;
  logic [PAT_ADDR_W-1:0] o_new_pattern_len;
  logic                  o_new_addr_valid;

  modport master (
    input  i_note_stb,
    input  i_note_done,
    output o_new_addr,
    output o_new_pattern_len,
    output o_new_addr_valid
  );

  modport slave (
    output i_note_stb,
    output i_note_done,
    input  o_new_addr,
    input  o_new_pattern_len,
    input  o_new_addr_valid
  );

endinterface

// File: rtl/pattern_sequencer.sv
// Song sequencer: walks order ROM, arms patterns for the note sequencer.
// Ports: i_clk, i_rst_n, i_start, i_stop, o_order_addr, i_order_data,
// o_playing, o_song_end, nsq (master link). Macro: PATTERN_SEQ_LOOP_EN.
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int ORDER_ADDR_W = 4,
  parameter int ORDER_LEN    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_stop,
  output logic [ORDER_ADDR_W-1:0] o_order_addr,
  input  logic [15:0]             i_order_data,
  output logic                    o_playing,
  output logic                    o_song_end,
  pattern_sequencer_if.master     nsq
);

  localparam logic [ORDER_ADDR_W-1:0] LAST_IDX =
    ORDER_ADDR_W'(ORDER_LEN - 1);

  state_t                  r_state;
  logic [ORDER_ADDR_W-1:0] r_idx;
  logic [OW_LEN_W-1:0]     r_note_cnt;
  logic [OW_REP_W-1:0]     r_rep_cnt;
  logic [OW_ADDR_W-1:0]    r_addr;
  logic [OW_LEN_W-1:0]     r_len;
  logic                    r_end;
  logic                    r_song_end;

  state_t                  w_state;
  logic [ORDER_ADDR_W-1:0] w_idx;
  logic [OW_LEN_W-1:0]     w_note_cnt;
  logic [OW_REP_W-1:0]     w_rep_cnt;
  logic [OW_ADDR_W-1:0]    w_addr;
  logic [OW_LEN_W-1:0]     w_len;
  logic                    w_end;
  logic                    w_song_end;
  logic                    w_unused;

  // bit 14 of the order word is reserved
  assign w_unused = i_order_data[14];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_note_cnt <= '0;
      r_rep_cnt  <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_end      <= 1'b0;
      r_song_end <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_idx      <= w_idx;
      r_note_cnt <= w_note_cnt;
      r_rep_cnt  <= w_rep_cnt;
      r_addr     <= w_addr;
      r_len      <= w_len;
      r_end      <= w_end;
      r_song_end <= w_song_end;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_idx      = r_idx;
    w_note_cnt = r_note_cnt;
    w_rep_cnt  = r_rep_cnt;
    w_addr     = r_addr;
    w_len      = r_len;
    w_end      = r_end;
    w_song_end = 1'b0;
    if (i_stop) begin
      w_state = S_IDLE;
    end else if (i_start) begin
      w_state    = S_FETCH;
      w_idx      = '0;
      w_note_cnt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_FETCH: w_state = S_LATCH;
        S_LATCH: begin
          // only reached after a fetch, so this is a first entry
          w_addr    = ow_addr(i_order_data);
          w_len     = ow_len(i_order_data);
          w_rep_cnt = ow_rep(i_order_data);
          w_end     = ow_end(i_order_data);
          w_state   = S_ARM;
        end
        S_ARM: begin
          if (nsq.i_note_stb) begin
            w_state    = S_PLAY;
            w_note_cnt = '0;
          end
        end
        S_PLAY: begin
          if (nsq.i_note_done) begin
            if (r_note_cnt != r_len) begin
              w_note_cnt = r_note_cnt + 1'b1;
            end else if (r_rep_cnt != '0) begin
              w_rep_cnt = r_rep_cnt - 1'b1;
              w_state   = S_ARM;
            end else if (r_end || r_idx == LAST_IDX) begin
              w_song_end = 1'b1;
`ifdef PATTERN_SEQ_LOOP_EN
              w_idx   = '0;
              w_state = S_FETCH;
`else
              w_state = S_IDLE;
`endif
            end else begin
              w_idx   = r_idx + 1'b1;
              w_state = S_FETCH;
            end
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  assign o_order_addr          = r_idx;
  assign o_playing             = (r_state != S_IDLE);
  assign o_song_end            = r_song_end;
  assign nsq.o_new_addr        = r_addr;
  assign nsq.o_new_pattern_len = r_len;
  assign nsq.o_new_addr_valid  = (r_state == S_ARM);

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with a 1-cycle-latency order ROM.
// Expectations follow PATTERN_SEQ_LOOP_EN when it is defined.
module tb_pattern_sequencer;

`ifdef PATTERN_SEQ_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [3:0]  order_addr;
  logic [15:0] order_data;
  logic        playing;
  logic        song_end;
  logic [15:0] rom [16];
  int          n_assert;
  int          n_fail;

  pattern_sequencer_if nsq();

  pattern_sequencer #(
    .ORDER_ADDR_W (4),
    .ORDER_LEN    (16)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_stop       (stop),
    .o_order_addr (order_addr),
    .i_order_data (order_data),
    .o_playing    (playing),
    .o_song_end   (song_end),
    .nsq          (nsq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) order_data <= rom[order_addr];

  function automatic logic [15:0] mk(
    input int a, input int l, input int r, input int e
  );
    logic [15:0] w;
    w = '0;
    w[4:0]   = a[4:0];
    w[9:5]   = l[4:0];
    w[13:10] = r[3:0];
    w[15]    = e[0];
    return w;
  endfunction

  task automatic chk(
    input string tag, input logic [31:0] obs, input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic note();
    nsq.i_note_stb = 1'b1;
    step();
    nsq.i_note_stb  = 1'b0;
    nsq.i_note_done = 1'b1;
    step();
    nsq.i_note_done = 1'b0;
  endtask

  task automatic clr_rom();
    for (int i = 0; i < 16; i++) rom[i] = '0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    nsq.i_note_stb  = 1'b0;
    nsq.i_note_done = 1'b0;
    clr_rom();
    #12;
    chk("rst_order_addr", 32'(order_addr), 0);
    chk("rst_new_addr", 32'(nsq.o_new_addr), 0);
    chk("rst_len", 32'(nsq.o_new_pattern_len), 0);
    chk("rst_valid", 32'(nsq.o_new_addr_valid), 0);
    chk("rst_playing", 32'(playing), 0);
    chk("rst_song_end", 32'(song_end), 0);
    rst_n = 1'b1;
    step();

    // basic load
    rom[0] = mk(3, 1, 0, 1);
    pulse_start();
    chk("b_fetch_playing", 32'(playing), 1);
    chk("b_fetch_valid", 32'(nsq.o_new_addr_valid), 0);
    idle(2);
    chk("b_arm_valid", 32'(nsq.o_new_addr_valid), 1);
    chk("b_arm_addr", 32'(nsq.o_new_addr), 3);
    chk("b_arm_len", 32'(nsq.o_new_pattern_len), 1);
    nsq.i_note_done = 1'b1;
    step();
    nsq.i_note_done = 1'b0;
    chk("b_done_in_arm", 32'(nsq.o_new_addr_valid), 1);
    note();
    chk("b_valid_drop", 32'(nsq.o_new_addr_valid), 0);
    chk("b_no_end_1", 32'(song_end), 0);
    idle(6);
    note();
    chk("b_song_end", 32'(song_end), 1);
    chk("b_playing_end", 32'(playing), 32'(LOOP));
    step();
    chk("b_end_pulse", 32'(song_end), 0);
`ifdef PATTERN_SEQ_LOOP_EN
    chk("b_loop_idx", 32'(order_addr), 0);
    step();
    chk("b_loop_valid", 32'(nsq.o_new_addr_valid), 1);
    chk("b_loop_addr", 32'(nsq.o_new_addr), 3);
    chk("b_loop_playing", 32'(playing), 1);
`endif
    pulse_stop();
    idle(2);

    // advance
    clr_rom();
    rom[0] = mk(5, 0, 0, 0);
    rom[1] = mk(12, 2, 0, 1);
    pulse_start();
    idle(2);
    chk("a_arm0_addr", 32'(nsq.o_new_addr), 5);
    note();
    idle(2);
    chk("a_idx1", 32'(order_addr), 1);
    chk("a_arm1_valid", 32'(nsq.o_new_addr_valid), 1);
    chk("a_arm1_addr", 32'(nsq.o_new_addr), 12);
    chk("a_arm1_len", 32'(nsq.o_new_pattern_len), 2);
    note();
    idle(6);
    note();
    chk("a_no_end_early", 32'(song_end), 0);
    idle(6);
    note();
    chk("a_song_end", 32'(song_end), 1);
    chk("a_playing_end", 32'(playing), 32'(LOOP));
    pulse_stop();
    idle(2);

    // repeat
    clr_rom();
    rom[0] = mk(7, 1, 2, 1);
    pulse_start();
    idle(2);
    for (int r = 0; r < 3; r++) begin
      chk("r_valid", 32'(nsq.o_new_addr_valid), 1);
      chk("r_addr", 32'(nsq.o_new_addr), 7);
      chk("r_no_refetch", 32'(order_addr), 0);
      note();
      idle(6);
      note();
      if (r < 2) begin
        chk("r_no_end", 32'(song_end), 0);
        idle(6);
      end
    end
    chk("r_song_end", 32'(song_end), 1);
    pulse_stop();
    idle(2);

    // stop and start together during PLAY
    pulse_start();
    idle(2);
    note();
    stop  = 1'b1;
    start = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    chk("ss_playing", 32'(playing), 0);
    chk("ss_valid", 32'(nsq.o_new_addr_valid), 0);
    idle(4);
    chk("ss_stays_idle", 32'(playing), 0);

    // restart while armed at index 1
    clr_rom();
    rom[0] = mk(5, 0, 0, 0);
    rom[1] = mk(12, 2, 0, 1);
    pulse_start();
    idle(2);
    note();
    idle(2);
    chk("rs_idx1", 32'(order_addr), 1);
    pulse_start();
    chk("rs_idx0", 32'(order_addr), 0);
    chk("rs_valid_drop", 32'(nsq.o_new_addr_valid), 0);
    chk("rs_playing", 32'(playing), 1);
    idle(2);
    chk("rs_rearm_addr", 32'(nsq.o_new_addr), 5);
    pulse_stop();

    // async reset while armed
    pulse_start();
    idle(2);
    chk("ar_valid_pre", 32'(nsq.o_new_addr_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(nsq.o_new_addr_valid), 0);
    chk("ar_new_addr", 32'(nsq.o_new_addr), 0);
    chk("ar_playing", 32'(playing), 0);
    #3;
    rst_n = 1'b1;
    idle(3);
    chk("ar_idle", 32'(playing), 0);

    // last order index without end flag
    clr_rom();
    for (int i = 0; i < 15; i++) rom[i] = mk(i + 1, 0, 0, 0);
    rom[15] = mk(20, 0, 0, 0);
    pulse_start();
    idle(2);
    for (int i = 0; i < 16; i++) begin
      chk("l_idx", 32'(order_addr), 32'(i));
      chk("l_addr", 32'(nsq.o_new_addr), (i < 15) ? 32'(i + 1) : 20);
      note();
      if (i < 15) begin
        chk("l_no_end", 32'(song_end), 0);
        idle(2);
      end
    end
    chk("l_song_end", 32'(song_end), 1);
    chk("l_playing", 32'(playing), 32'(LOOP));
    chk("l_idx_after", 32'(order_addr), 32'(LOOP ? 0 : 15));
    pulse_stop();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
